spi_reg_slave: RTL and testbench

SPI-mode-0 register-access slave sitting directly behind the chip's `sck`/`ss`/`mosi` inputs and driving `miso`/`miso_en`. It oversamples the SPI pins in the system clock domain, decodes a command byte plus a data-byte stream, and issues single-cycle register write strobes and read requests toward the game's configuration/register file. It is the only consumer of the SPI pins and the only producer of `uio_out[0]`/`uio_oe[0]`.

---
 rtl/breakout_pkg.sv | 13 +
 rtl/spi_pin_sync.sv | 31 +++
 rtl/spi_reg_slave.sv | 142 ++++++++++++++
 tb/tb_spi_reg_slave.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared SPI definitions: command layout, byte width and the slave FSM state type.
package breakout_pkg;

  localparam int SPI_CMD_RW_BIT = 7;
  localparam int SPI_BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer plus an edge-detect register for one asynchronous SPI pin.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= pin;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-access slave: command byte then streaming write/read data bytes.
// Define SPI_READBACK_EN to build the miso read path; otherwise read commands are swallowed.
module spi_reg_slave
  import breakout_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data
);

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  // ss idles high so the synchronizer resets high: no false fall and miso_en low in reset
  spi_pin_sync #(.RST_VAL(1'b0)) u_sck  (.clk(clk), .rst_n(rst_n), .pin(sck),
                                          .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  spi_pin_sync #(.RST_VAL(1'b1)) u_ss   (.clk(clk), .rst_n(rst_n), .pin(ss),
                                          .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall));
  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .pin(mosi),
                                          .lvl(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  spi_state_t                state_q, state_d;
  logic [2:0]                bit_cnt_q;
  logic [SPI_BYTE_W-2:0]     rx_q;
  logic [ADDR_W-1:0]         addr_q;
  logic                      rw_q;
  logic                      wr_vld_p0;
  logic                      ld_vld_p0;
  logic                      bit_rise;
  logic                      byte_done;
  logic [SPI_BYTE_W-1:0]     rx_byte;

  // ss rise always wins over a coincident sck rise, discarding the partial byte
  assign bit_rise  = sck_rise & ~ss_rise & (state_q != IDLE);
  assign byte_done = bit_rise & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_q, mosi_lvl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ss_fall) state_d = CMD;
        CMD:     if (byte_done) state_d = DATA;
        default: state_d = state_q;
      endcase
    end
  end

  // p0: byte assembly, address tracking, pending write/load flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wr_vld_p0 <= 1'b0;
      ld_vld_p0 <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_vld_p0 <= 1'b0;
      ld_vld_p0 <= 1'b0;
      // p1: write strobe lags the byte completion by one clk
      wr_en     <= wr_vld_p0;
      if (ss_fall && state_q == IDLE) begin
        bit_cnt_q <= '0;
        rx_q      <= '0;
      end else if (bit_rise) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        rx_q      <= rx_byte[SPI_BYTE_W-2:0];
      end
      if (byte_done) begin
        if (state_q == CMD) begin
          addr_q    <= rx_byte[ADDR_W-1:0];
          rw_q      <= rx_byte[SPI_CMD_RW_BIT];
          ld_vld_p0 <= rx_byte[SPI_CMD_RW_BIT];
        end else begin
          if (!rw_q) begin
            wr_vld_p0 <= 1'b1;
            wr_addr   <= addr_q;
            wr_data   <= rx_byte;
          end else begin
            ld_vld_p0 <= 1'b1;
          end
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [SPI_BYTE_W-1:0] tx_q;

  // p1: the first fall after a load (bit counter 0) keeps bit7 on the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
    end else if (ss_rise) begin
      tx_q <= '0;
    end else if (ld_vld_p0) begin
      tx_q <= rd_data;
    end else if (sck_fall && state_q != IDLE && bit_cnt_q != 3'd0) begin
      tx_q <= {tx_q[SPI_BYTE_W-2:0], 1'b0};
    end
  end

  assign miso    = tx_q[SPI_BYTE_W-1];
  assign miso_en = ~ss_lvl;
  assign rd_addr = addr_q;

  logic unused_pins;
  assign unused_pins = ^{sck_lvl, mosi_rise, mosi_fall};
`else
  assign miso    = 1'b0;
  assign miso_en = 1'b0;
  assign rd_addr = '0;

  logic unused_pins;
  assign unused_pins = ^{sck_lvl, mosi_rise, mosi_fall, ss_lvl, ld_vld_p0, rd_data};
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: table-driven write bursts, read, abort and reset cases.
module tb_spi_reg_slave;
  localparam int ADDR_W = 4;
  localparam int HALF   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sck = 1'b0;
  logic              ss = 1'b1;
  logic              mosi = 1'b0;
  logic              miso, miso_en, wr_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0]        wr_data, rd_data;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                due;
  } wr_exp_t;
  wr_exp_t sb_q[$];

  typedef struct {
    logic [7:0]        cmd;
    int                n;
    logic [7:0]        d[2];
    logic [ADDR_W-1:0] a[2];
  } vec_t;
  vec_t vecs[4];

  spi_reg_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_en(miso_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // register file model: each register reads back as addr * 0x10
  assign rd_data = {rd_addr, 4'h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wr_en: got addr 0x%0h data 0x%0h at cycle %0d, expected no write",
                 wr_addr, wr_data, cyc);
      end else begin
        wr_exp_t e;
        e = sb_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("wr_latency_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives the top nbits of b MSB-first; captures miso just before each rise.
  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit exp_wr,
                          input logic [ADDR_W-1:0] a, output logic [7:0] rx, output int en_cnt);
    rx = '0;
    en_cnt = 0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      @(negedge clk);
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], miso};
      if (miso_en === 1'b1) en_cnt++;
      sck = 1'b1;
      if (i == 0 && exp_wr) sb_q.push_back('{a, b, cyc + 4});
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_begin();
    @(negedge clk);
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx0, rx1, rxc;
    int en0, en1, enc, bad, exp_en;
    logic [7:0] exp_r0, exp_r1;
    logic [ADDR_W-1:0] exp_rd_addr;

    vecs[0] = '{cmd: 8'h03, n: 1, d: '{8'hA5, 8'h00}, a: '{4'd3,  4'd0}};
    vecs[1] = '{cmd: 8'h0F, n: 2, d: '{8'h11, 8'h22}, a: '{4'd15, 4'd0}};
    vecs[2] = '{cmd: 8'h7A, n: 2, d: '{8'h5C, 8'hC3}, a: '{4'd10, 4'd11}};
    vecs[3] = '{cmd: 8'h00, n: 2, d: '{8'hFF, 8'h00}, a: '{4'd0,  4'd1}};

`ifdef SPI_READBACK_EN
    exp_en = 8; exp_r0 = 8'h20; exp_r1 = 8'h30; exp_rd_addr = 4'd4;
`else
    exp_en = 0; exp_r0 = 8'h00; exp_r1 = 8'h00; exp_rd_addr = 4'd0;
`endif

    // reset with ss high
    repeat (5) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_miso_en", miso_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (miso_en !== 1'b0 || wr_en !== 1'b0) bad++;
    end
    chk("idle_quiet_100clk", bad, 0);

    // write bursts, including address wrap and ignored command bits
    for (int v = 0; v < 4; v++) begin
      spi_begin();
      spi_bits(vecs[v].cmd, 8, 1'b0, '0, rxc, enc);
      for (int j = 0; j < vecs[v].n; j++)
        spi_bits(vecs[v].d[j], 8, 1'b1, vecs[v].a[j], rx0, en0);
      spi_end();
    end

    // read of addresses 2 and 3 with dummy mosi bytes
    spi_begin();
    spi_bits(8'h82, 8, 1'b0, '0, rxc, enc);
    spi_bits(8'hFF, 8, 1'b0, '0, rx0, en0);
    spi_bits(8'h00, 8, 1'b0, '0, rx1, en1);
    chk("rd_addr_after_read", rd_addr, exp_rd_addr);
    spi_end();
    chk("read_byte0_miso", rx0, exp_r0);
    chk("read_byte1_miso", rx1, exp_r1);
    chk("read_cmd_miso_en", enc, exp_en);
    chk("read_byte0_miso_en", en0, exp_en);
    chk("read_byte1_miso_en", en1, exp_en);

    // abort after 5 bits of a data byte, then a clean transaction
    spi_begin();
    spi_bits(8'h01, 8, 1'b0, '0, rxc, enc);
    spi_bits(8'hC9, 5, 1'b0, '0, rx0, en0);
    spi_end();
    chk("abort_miso_en_idle", miso_en, 0);
    spi_begin();
    spi_bits(8'h01, 8, 1'b0, '0, rxc, enc);
    spi_bits(8'h7E, 8, 1'b1, 4'd1, rx0, en0);
    spi_end();

    // asynchronous reset in the middle of a data byte
    spi_begin();
    spi_bits(8'h05, 8, 1'b0, '0, rxc, enc);
    spi_bits(8'hE7, 3, 1'b0, '0, rx0, en0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso", miso, 0);
    chk("midrst_miso_en", miso_en, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    sck = 1'b0;
    ss = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_begin();
    spi_bits(8'h05, 8, 1'b0, '0, rxc, enc);
    spi_bits(8'h99, 8, 1'b1, 4'd5, rx0, en0);
    spi_end();

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
